// File: rtl/stop_watch_ctrl.sv
// Stopwatch control front-end: debounces run/clear/lap buttons, sequences the
// IDLE/RUN/STOP/LAP FSM and divides the system clock down to the count pulse.
module stop_watch_ctrl #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned PLS_HZ       = 100,
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_run,
  input  logic       btn_clr,
  input  logic       btn_lap,
  output logic       plso,
  output logic       clr,
  output logic       lap_hold,
  output logic       running,
  output logic [1:0] state
);

  localparam int unsigned Div  = CLK_FREQ / PLS_HZ;
  localparam int unsigned PreW = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned DebW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(Div - 1);
  localparam logic [DebW-1:0] DebMax = DebW'(DEBOUNCE_CYC - 1);

  localparam int unsigned BtnRun = 0;
  localparam int unsigned BtnClr = 1;
  localparam int unsigned BtnLap = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StStop = 2'd2,
    StLap  = 2'd3
  } state_e;

  // Button conditioning
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      deb_lvl_q, deb_lvl_d;
  logic [2:0]      ev_q, ev_d;
  logic [DebW-1:0] deb_cnt_q [3];
  logic [DebW-1:0] deb_cnt_d [3];

  // FSM and prescaler
  state_e          state_q, state_d;
  logic [PreW-1:0] pre_q, pre_d;
  logic            plso_q, plso_d;
  logic            clr_q, clr_d;
  logic            running_q, running_d;
  logic            lap_hold_q, lap_hold_d;

  logic            run_ev, clr_ev, lap_ev;
  logic            cnt_now, cnt_next;

  assign btn_raw = {btn_lap, btn_clr, btn_run};

  // The counter only advances while the synced level disagrees with the accepted
  // level, so any glitch back to the accepted level restarts the stability window.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      deb_lvl_d[i] = deb_lvl_q[i];
      if (sync2_q[i] == deb_lvl_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DebMax) begin
        deb_lvl_d[i] = sync2_q[i];
        deb_cnt_d[i] = '0;
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
    ev_d = deb_lvl_d & ~deb_lvl_q;
  end

  // Only one event per cycle survives: run beats clear beats lap.
  assign run_ev = ev_q[BtnRun];
  assign clr_ev = ev_q[BtnClr] & ~ev_q[BtnRun];
  assign lap_ev = ev_q[BtnLap] & ~ev_q[BtnClr] & ~ev_q[BtnRun];

  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run_ev) begin
          state_d = StRun;
        end else if (clr_ev) begin
          clr_d = 1'b1;
        end
      end
      StRun: begin
        if (run_ev) begin
          state_d = StStop;
        end else if (lap_ev) begin
          state_d = StLap;
        end
      end
      StLap: begin
        if (run_ev) begin
          state_d = StStop;
        end else if (lap_ev) begin
          state_d = StRun;
        end
      end
      StStop: begin
        if (run_ev) begin
          state_d = StRun;
        end else if (clr_ev) begin
          state_d = StIdle;
          clr_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    running_d  = (state_d == StRun) || (state_d == StLap);
    lap_hold_d = (state_d == StLap);
  end

  assign cnt_now  = (state_q == StRun) || (state_q == StLap);
  assign cnt_next = (state_d == StRun) || (state_d == StLap);

  // A wrap that coincides with stopping is deferred: hold at PreMax so the pulse
  // is issued on the first counting cycle after resume instead of being lost.
  always_comb begin
    pre_d  = pre_q;
    plso_d = 1'b0;
    if (state_d == StIdle) begin
      pre_d = '0;
    end else if (cnt_now) begin
      if (pre_q == PreMax) begin
        if (cnt_next) begin
          pre_d  = '0;
          plso_d = 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_lvl_q  <= '0;
      ev_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= '0;
      end
      state_q    <= StIdle;
      pre_q      <= '0;
      plso_q     <= 1'b0;
      clr_q      <= 1'b0;
      running_q  <= 1'b0;
      lap_hold_q <= 1'b0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      deb_lvl_q  <= deb_lvl_d;
      ev_q       <= ev_d;
      for (int i = 0; i < 3; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
      state_q    <= state_d;
      pre_q      <= pre_d;
      plso_q     <= plso_d;
      clr_q      <= clr_d;
      running_q  <= running_d;
      lap_hold_q <= lap_hold_d;
    end
  end

  assign plso     = plso_q;
  assign clr      = clr_q;
  assign lap_hold = lap_hold_q;
  assign running  = running_q;
  assign state    = state_q;

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Directed bench for stop_watch_ctrl with DIV=10 and a 4-cycle debounce window.
module tb_stop_watch_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_run = 1'b0;
  logic       btn_clr = 1'b0;
  logic       btn_lap = 1'b0;
  logic       plso, clr, lap_hold, running;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int plso_cnt = 0;
  int clr_cnt = 0;

  always #5 clk = ~clk;

  stop_watch_ctrl #(
    .CLK_FREQ    (1000),
    .PLS_HZ      (100),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_run (btn_run),
    .btn_clr (btn_clr),
    .btn_lap (btn_lap),
    .plso    (plso),
    .clr     (clr),
    .lap_hold(lap_hold),
    .running (running),
    .state   (state)
  );

  // Pulses are tallied on the edge that ends the cycle in which they were high.
  always @(posedge clk) begin
    if (plso === 1'b1) plso_cnt <= plso_cnt + 1;
    if (clr === 1'b1) clr_cnt <= clr_cnt + 1;
  end

  typedef struct {
    bit run;
    bit clr;
    bit lap;
    int cyc;
    int st;
    int plso_n;
    int plso_now;
    int clr_n;
    int clr_now;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(bit r, bit c, bit l, int n, int st, int pn, int pnow, int cn,
                              int cnow);
    vec_t v;
    v.run = r; v.clr = c; v.lap = l; v.cyc = n; v.st = st;
    v.plso_n = pn; v.plso_now = pnow; v.clr_n = cn; v.clr_now = cnow;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    int p0, c0, exp_run, exp_lap;

    // Press-to-state latency is 7 edges; the counter wraps every 10 counting cycles.
    tbl[0]  = mk(1, 0, 0, 10, 1, 0, 0, 0, 0);  // start, held: one transition
    tbl[1]  = mk(0, 0, 0, 40, 1, 4, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 10, 1, 1, 0, 0, 0);  // 5 pulses in first 50 RUN cycles
    tbl[3]  = mk(0, 0, 1, 10, 3, 1, 0, 0, 0);  // lap in
    tbl[4]  = mk(0, 0, 0, 10, 3, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 1, 10, 1, 1, 0, 0, 0);  // lap out
    tbl[6]  = mk(0, 1, 0, 10, 1, 1, 0, 0, 0);  // clr ignored in RUN
    tbl[7]  = mk(0, 0, 0, 6, 1, 0, 0, 0, 0);
    tbl[8]  = mk(1, 0, 0, 10, 2, 1, 0, 0, 0);  // stop with prescaler at 6
    tbl[9]  = mk(0, 0, 0, 37, 2, 0, 0, 0, 0);
    tbl[10] = mk(1, 0, 0, 7, 1, 0, 0, 0, 0);   // resume edge
    tbl[11] = mk(0, 0, 0, 4, 1, 0, 1, 0, 0);   // plso 4 cycles after resume
    tbl[12] = mk(0, 0, 0, 1, 1, 1, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 30, 1, 3, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 10, 2, 0, 0, 0, 0);  // stop
    tbl[15] = mk(0, 0, 0, 10, 2, 0, 0, 0, 0);
    tbl[16] = mk(0, 1, 0, 7, 0, 0, 0, 0, 1);   // clear from STOP
    tbl[17] = mk(0, 0, 0, 1, 0, 0, 0, 1, 0);   // exactly one clr cycle
    tbl[18] = mk(1, 0, 0, 7, 1, 0, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 10, 1, 0, 1, 0, 0);  // full period: prescaler was cleared
    tbl[20] = mk(0, 0, 0, 3, 1, 1, 0, 0, 0);
    tbl[21] = mk(1, 0, 0, 10, 2, 0, 0, 0, 0);  // stop exactly on wrap: pulse deferred
    tbl[22] = mk(0, 0, 0, 10, 2, 0, 0, 0, 0);
    tbl[23] = mk(1, 1, 0, 10, 1, 1, 0, 0, 0);  // run+clr: run wins, deferred pulse
    tbl[24] = mk(0, 0, 0, 10, 1, 1, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("reset_state", 0, int'(state), 0);
    chk("reset_plso", 0, int'(plso), 0);
    chk("reset_clr", 0, int'(clr), 0);
    chk("reset_running", 0, int'(running), 0);
    chk("reset_lap_hold", 0, int'(lap_hold), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      btn_run = tbl[i].run;
      btn_clr = tbl[i].clr;
      btn_lap = tbl[i].lap;
      p0 = plso_cnt;
      c0 = clr_cnt;
      repeat (tbl[i].cyc) @(negedge clk);
      exp_run = (tbl[i].st == 1 || tbl[i].st == 3) ? 1 : 0;
      exp_lap = (tbl[i].st == 3) ? 1 : 0;
      chk("state", i, int'(state), tbl[i].st);
      chk("running", i, int'(running), exp_run);
      chk("lap_hold", i, int'(lap_hold), exp_lap);
      chk("plso_count", i, plso_cnt - p0, tbl[i].plso_n);
      chk("plso_level", i, int'(plso), tbl[i].plso_now);
      chk("clr_count", i, clr_cnt - c0, tbl[i].clr_n);
      chk("clr_level", i, int'(clr), tbl[i].clr_now);
    end

    // Bouncing run button: no event until the level is steady for the full window.
    btn_run = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      btn_run = (i % 2 == 0);
      repeat (2) @(negedge clk);
      chk("bounce_idle", i, int'(state), 0);
    end
    btn_run = 1'b1;
    repeat (6) @(negedge clk);
    chk("bounce_not_yet", 0, int'(state), 0);
    @(negedge clk);
    chk("bounce_run", 0, int'(state), 1);
    repeat (5) @(negedge clk);
    chk("held_no_repeat", 0, int'(state), 1);
    chk("pre_reset_running", 0, int'(running), 1);

    // Asynchronous reset mid-count (prescaler at 5).
    btn_run = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_state", 0, int'(state), 0);
    chk("async_plso", 0, int'(plso), 0);
    chk("async_clr", 0, int'(clr), 0);
    chk("async_lap_hold", 0, int'(lap_hold), 0);
    chk("async_running", 0, int'(running), 0);
    @(negedge clk);
    rst = 1'b1;
    p0 = plso_cnt;
    repeat (30) @(negedge clk);
    chk("post_reset_plso", 0, plso_cnt - p0, 0);
    chk("post_reset_state", 0, int'(state), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
